distribute_dst_tag_scheduler: RTL

Command scheduler for a binary 1-to-NUM_DST distribution tree built from single-bit destination-tag 1x2 distribute stages. It accepts packets that carry a destination bitmask and serializes each multicast packet into one unicast beat per set bit. For each beat it drives the tree root with data, valid, enable and a NUM_STAGE-bit destination-tag command, and applies valid/ready backpressure on both sides.

---
 rtl/distribute_pkg.sv | 30 +++
 rtl/lowest_set_bit_enc.sv | 33 +++
 rtl/distribute_dst_tag_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/distribute_pkg.sv
// Shared definitions for the destination-tag distribution tree scheduler.
// Provides the clog2 helper, the stage-count derivation, the dummy data bit
// and the scheduler state encoding.
package distribute_pkg;

    // Ceiling log2, minimum 1 so that a 2-leaf tree still has a 1-bit command.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned x = 1; x < v; x = x << 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // One tag bit is consumed per 1x2 stage, so stage count equals the command width.
    function automatic int unsigned num_stage(input int unsigned num_dst,
                                              input int unsigned tag_width);
        return clog2(num_dst) * tag_width;
    endfunction

    // Fill bit for the payload whenever no beat is presented.
    localparam logic DUMMY_BIT = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/lowest_set_bit_enc.sv
// Lowest-set-bit encoder for the pending destination mask.
// Ports:
//   i_mask    - destination bitmask still to be served
//   o_idx     - index of the lowest set bit (0 when the mask is empty)
//   o_onehot  - one-hot of that bit, used to retire the served destination
//   o_is_last - exactly one bit set
module lowest_set_bit_enc
    import distribute_pkg::*;
#(
    parameter int unsigned NUM_DST = 8,
    localparam int unsigned IDX_W = clog2(NUM_DST)
) (
    input  logic [NUM_DST-1:0] i_mask,
    output logic [IDX_W-1:0]   o_idx,
    output logic [NUM_DST-1:0] o_onehot,
    output logic               o_is_last
);

    // Scan downward so the last hit written is the lowest index.
    always_comb begin
        o_idx = '0;
        for (int i = NUM_DST - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign o_onehot  = i_mask & (~i_mask + NUM_DST'(1));
    assign o_is_last = (i_mask != '0) && ((i_mask & (i_mask - NUM_DST'(1))) == '0);

endmodule

// File: rtl/distribute_dst_tag_scheduler.sv
// Serializes multicast packets into per-destination unicast beats for a
// binary 1-to-NUM_DST distribution tree of 1-bit-tag 1x2 stages.
// Ports:
//   clk, rst_n               - clock, synchronous active-low reset
//   i_en                     - global enable, 0 freezes everything
//   i_valid/i_ready          - upstream packet handshake
//   i_data_bus, i_dst_mask   - packet payload and destination bitmask
//   o_valid/o_ready          - beat handshake towards the tree root
//   o_data_bus, o_cmd        - beat payload and destination tag (MSB = first stage)
//   o_en                     - tree enable (follows i_en)
//   o_pkt_done               - pulse when the last beat of a packet is accepted
//   o_drop_cnt               - saturating count of zero-mask packets
module distribute_dst_tag_scheduler
    import distribute_pkg::*;
#(
    parameter int unsigned DATA_WIDTH            = 32,
    parameter int unsigned NUM_DST               = 8,
    parameter int unsigned DESTINATION_TAG_WIDTH = 1,
    localparam int unsigned NUM_STAGE = num_stage(NUM_DST, DESTINATION_TAG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_data_bus,
    input  logic [NUM_DST-1:0]    i_dst_mask,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data_bus,
    output logic [NUM_STAGE-1:0]  o_cmd,
    output logic                  o_en,
    output logic                  o_pkt_done,
    output logic [15:0]           o_drop_cnt
);

    localparam int unsigned            IDX_W      = clog2(NUM_DST);
    localparam int unsigned            CNT_W      = 16;
    localparam logic [DATA_WIDTH-1:0]  DUMMY_DATA = {DATA_WIDTH{DUMMY_BIT}};
    localparam logic [CNT_W-1:0]       CNT_MAX    = {CNT_W{1'b1}};

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_DST-1:0]    mask_q, mask_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

    logic [IDX_W-1:0]      enc_idx;
    logic [NUM_DST-1:0]    enc_onehot;
    logic                  enc_is_last;
    logic                  active;
    logic                  pkt_xfer;

    lowest_set_bit_enc #(
        .NUM_DST (NUM_DST)
    ) u_enc (
        .i_mask    (mask_q),
        .o_idx     (enc_idx),
        .o_onehot  (enc_onehot),
        .o_is_last (enc_is_last)
    );

    // Nothing transfers while disabled or held in reset.
    assign active   = i_en & rst_n;
    assign pkt_xfer = i_valid & i_ready;

    // Next-state and handshake logic.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        mask_d     = mask_q;
        drop_cnt_d = drop_cnt_q;
        o_valid    = 1'b0;
        i_ready    = 1'b0;
        o_pkt_done = 1'b0;

        if (active) begin
            unique case (state_q)
                ST_IDLE: begin
                    i_ready = 1'b1;
                end
                ST_ISSUE: begin
                    o_valid = 1'b1;
                    if (o_ready) begin
                        mask_d = mask_q & ~enc_onehot;
                        if (enc_is_last) begin
                            o_pkt_done = 1'b1;
                            i_ready    = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A new packet may only land when the previous one is fully retired.
            if (pkt_xfer) begin
                data_d = i_data_bus;
                mask_d = i_dst_mask;
                if (i_dst_mask == '0) begin
                    state_d    = ST_IDLE;
                    drop_cnt_d = (drop_cnt_q == CNT_MAX) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_ISSUE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            mask_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Leaf index in binary doubles as the per-stage tag, MSB first.
    assign o_cmd      = NUM_STAGE'(enc_idx);
    assign o_data_bus = o_valid ? data_q : DUMMY_DATA;
    assign o_en       = i_en;
    assign o_drop_cnt = drop_cnt_q;

endmodule
